// File: rtl/microp_ultrasonic_echo_if.sv
// Avalon-MM slave bus for the dual-channel ultrasonic echo timer.
// Word-addressed, zero-wait-state reads, active-low write strobe.
interface microp_ultrasonic_echo_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/microp_ultrasonic_echo.sv
// Dual-channel ultrasonic echo pulse-width timer with timeout detection,
// sticky W1C status flags and a registered level interrupt.
module microp_ultrasonic_echo #(
    parameter int unsigned TIMEOUT_CYCLES = 1250000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    microp_ultrasonic_echo_if.slave bus,
    input  logic [1:0]              echo_in,
    output logic                    irq
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STUCK
    } state_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0] s1_q, s1_d;
    logic [1:0] s_q, s_d;
    logic [1:0] sd_q, sd_d;
    logic [1:0] vld_q, vld_d;
    logic [1:0] arm_q, arm_d;
    logic [1:0] done_q, done_d;
    logic [1:0] tmo_q, tmo_d;
    logic [1:0] ovr_q, ovr_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    state_t           state_q [2];
    state_t           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [CNT_W-1:0] width_q [2];
    logic [CNT_W-1:0] width_d [2];

    logic       wr;
    logic [5:0] w1c;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] busy;
    logic       unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign w1c       = (wr && bus.address == 2'd0) ? bus.writedata[5:0] : 6'd0;
    assign unused_wd = ^bus.writedata[31:6];

    // A rising edge only counts once the channel has seen a genuine low level
    // after reset, so an echo already high at release is ignored.
    assign rise = s_q & ~sd_q & arm_q;
    assign fall = ~s_q & sd_q;

    always_comb begin
        s1_d   = echo_in;
        s_d    = s1_q;
        sd_d   = s_q;
        vld_d  = {vld_q[0], 1'b1};
        arm_d  = arm_q | ({2{vld_q[1]}} & ~s_q);
        ctrl_d = ctrl_q;
        done_d = done_q & ~w1c[1:0];
        tmo_d  = tmo_q & ~w1c[3:2];
        ovr_d  = ovr_q & ~w1c[5:4];
        irq_d  = |(ctrl_q[1:0] & (done_q | tmo_q));
        if (wr && bus.address == 2'd3) begin
            ctrl_d = bus.writedata[3:0];
        end
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            width_d[n] = width_q[n];
            if (!ctrl_q[2+n]) begin
                state_d[n] = IDLE;
                cnt_d[n]   = '0;
            end else begin
                unique case (state_q[n])
                    IDLE: begin
                        if (rise[n]) begin
                            state_d[n] = MEASURE;
                            cnt_d[n]   = CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (fall[n]) begin
                            state_d[n] = IDLE;
                            width_d[n] = cnt_q[n];
                            done_d[n]  = 1'b1;
                            if (done_q[n]) ovr_d[n] = 1'b1;
                        end else if (s_q[n]) begin
                            if (cnt_q[n] == TMO) begin
                                state_d[n] = STUCK;
                                width_d[n] = TMO;
                                tmo_d[n]   = 1'b1;
                            end else begin
                                cnt_d[n] = cnt_q[n] + CNT_W'(1);
                            end
                        end
                    end
                    STUCK: begin
                        if (!s_q[n]) state_d[n] = IDLE;
                    end
                    default: state_d[n] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s_q    <= '0;
            sd_q   <= '0;
            vld_q  <= '0;
            arm_q  <= '0;
            done_q <= '0;
            tmo_q  <= '0;
            ovr_q  <= '0;
            ctrl_q <= 4'hC;
            irq_q  <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
                width_q[n] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s_q    <= s_d;
            sd_q   <= sd_d;
            vld_q  <= vld_d;
            arm_q  <= arm_d;
            done_q <= done_d;
            tmo_q  <= tmo_d;
            ovr_q  <= ovr_d;
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                width_q[n] <= width_d[n];
            end
        end
    end

    assign busy[0] = (state_q[0] != IDLE);
    assign busy[1] = (state_q[1] != IDLE);
    assign irq     = irq_q;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: bus.readdata = {24'd0, busy, ovr_q, tmo_q, done_q};
            2'd1: bus.readdata = 32'(width_q[0]);
            2'd2: bus.readdata = 32'(width_q[1]);
            2'd3: bus.readdata = {28'd0, ctrl_q};
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_microp_ultrasonic_echo.sv
// Directed bench: dut_a uses the default timeout, dut_b a 100-cycle timeout;
// both see the same bus writes and echo lines.
module tb_microp_ultrasonic_echo;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] echo;
    logic       irq_a, irq_b;
    int         checks   = 0;
    int         failures = 0;

    microp_ultrasonic_echo_if bus_a ();
    microp_ultrasonic_echo_if bus_b ();

    assign bus_b.address    = bus_a.address;
    assign bus_b.chipselect = bus_a.chipselect;
    assign bus_b.write_n    = bus_a.write_n;
    assign bus_b.writedata  = bus_a.writedata;

    microp_ultrasonic_echo dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a),
        .echo_in (echo),
        .irq     (irq_a)
    );

    microp_ultrasonic_echo #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (24)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_b),
        .echo_in (echo),
        .irq     (irq_b)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        bus_a.address    = a;
        bus_a.writedata  = d;
        bus_a.chipselect = 1'b1;
        bus_a.write_n    = 1'b0;
        tick(1);
        bus_a.chipselect = 1'b0;
        bus_a.write_n    = 1'b1;
    endtask

    task automatic rd_a(string tag, logic [1:0] a, logic [31:0] exp);
        bus_a.address    = a;
        bus_a.chipselect = 1'b1;
        #1;
        chk(tag, bus_a.readdata, exp);
        bus_a.chipselect = 1'b0;
    endtask

    task automatic rd_b(string tag, logic [1:0] a, logic [31:0] exp);
        bus_a.address    = a;
        bus_a.chipselect = 1'b1;
        #1;
        chk(tag, bus_b.readdata, exp);
        bus_a.chipselect = 1'b0;
    endtask

    task automatic pulse(logic [1:0] m, int n);
        echo = m;
        tick(n);
        echo = 2'b00;
    endtask

    initial begin
        bus_a.address    = 2'd0;
        bus_a.chipselect = 1'b0;
        bus_a.write_n    = 1'b1;
        bus_a.writedata  = '0;
        echo  = 2'b00;
        reset = 1'b1;
        tick(2);
        rd_a("rst_status", 2'd0, 32'h0);
        rd_a("rst_ctrl", 2'd3, 32'hC);
        chk("rst_irq", {31'd0, irq_a}, 32'h0);
        reset = 1'b0;
        tick(3);
        rd_a("rst_width0", 2'd1, 32'h0);

        // single 1000-cycle pulse on channel 0
        pulse(2'b01, 1000);
        tick(5);
        rd_a("w0_1000", 2'd1, 32'd1000);
        rd_a("st_done0", 2'd0, 32'h01);
        wr(2'd0, 32'h01);
        rd_a("st_clr", 2'd0, 32'h00);

        // two pulses without clearing: overrun and irq timing
        wr(2'd3, 32'hD);
        pulse(2'b01, 50);
        tick(3);
        rd_a("st_first50", 2'd0, 32'h01);
        chk("irq_lag", {31'd0, irq_a}, 32'h0);
        tick(1);
        chk("irq_set", {31'd0, irq_a}, 32'h1);
        tick(10);
        pulse(2'b01, 50);
        tick(5);
        rd_a("w0_50", 2'd1, 32'd50);
        rd_a("st_ovr", 2'd0, 32'h11);
        chk("irq_ovr", {31'd0, irq_a}, 32'h1);
        wr(2'd0, 32'h11);
        rd_a("st_clr2", 2'd0, 32'h00);
        chk("irq_hold", {31'd0, irq_a}, 32'h1);
        tick(1);
        chk("irq_drop", {31'd0, irq_a}, 32'h0);

        // W1C lands on the same edge that sets done[0]
        pulse(2'b01, 20);
        tick(2);
        wr(2'd0, 32'h01);
        rd_a("set_wins", 2'd0, 32'h01);
        rd_a("w0_20", 2'd1, 32'd20);
        wr(2'd0, 32'h01);
        tick(2);
        chk("irq_off", {31'd0, irq_a}, 32'h0);

        // disabling channel 0 mid-measurement
        echo = 2'b01;
        tick(20);
        rd_a("busy0", 2'd0, 32'h40);
        wr(2'd3, 32'h9);
        tick(1);
        rd_a("abort_busy", 2'd0, 32'h00);
        echo = 2'b00;
        tick(5);
        rd_a("abort_flags", 2'd0, 32'h00);
        rd_a("abort_w0", 2'd1, 32'd20);
        wr(2'd3, 32'hD);

        // timeout on channel 1 (dut_b times out, dut_a measures)
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        echo = 2'b10;
        tick(300);
        rd_b("tmo_status", 2'd0, 32'h88);
        rd_b("tmo_w1", 2'd2, 32'd100);
        rd_a("long_busy", 2'd0, 32'h80);
        echo = 2'b00;
        tick(5);
        rd_b("tmo_after", 2'd0, 32'h08);
        rd_a("long_done", 2'd0, 32'h02);
        rd_a("long_w1", 2'd2, 32'd300);

        // reset mid-pulse, released while echo is still high
        echo = 2'b11;
        tick(30);
        reset = 1'b1;
        #1;
        rd_a("mid_status", 2'd0, 32'h0);
        rd_a("mid_w0", 2'd1, 32'h0);
        rd_a("mid_w1", 2'd2, 32'h0);
        rd_a("mid_ctrl", 2'd3, 32'hC);
        chk("mid_irq", {31'd0, irq_a}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(20);
        rd_a("no_start", 2'd0, 32'h00);
        echo = 2'b00;
        tick(5);
        rd_a("no_done", 2'd0, 32'h00);
        rd_a("no_w0", 2'd1, 32'h0);
        pulse(2'b01, 7);
        tick(5);
        rd_a("fresh_w0", 2'd1, 32'd7);
        rd_a("fresh_st", 2'd0, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
